// File: rtl/linebuffer_ctrl_pkg.sv
// Shared types for the sprite line-buffer sequencer: FSM encodings, buffer geometry and the strobe bundle.
// Helper functions map {bank, x[0]} onto per-buffer one-hot strobes and packed 8-bit address lanes.
package linebuffer_ctrl_pkg;

    localparam int unsigned LB_DEPTH = 192;
    localparam int unsigned LB_XMAX  = 384;

    typedef enum logic [1:0] {
        LB_W_IDLE = 2'd0,
        LB_W_LOAD = 2'd1,
        LB_W_RUN  = 2'd2
    } wr_state_t;

    typedef enum logic [2:0] {
        LB_R_IDLE = 3'd0,
        LB_R_WAIT = 3'd1,
        LB_R_ADDR = 3'd2,
        LB_R_CLR  = 3'd3,
        LB_R_DONE = 3'd4
    } rd_state_t;

    // One side's contribution to the four buffers' control pins.
    typedef struct packed {
        logic [3:0]  ck;
        logic [3:0]  load;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [3:0]  clr;
    } lb_ctl_t;

    localparam lb_ctl_t LB_CTL_IDLE = '{ck: 4'h0, load: 4'hF, addr: 32'h0, we: 4'h0, clr: 4'h0};

    function automatic logic [1:0] lb_buf_idx(input logic bank, input logic x0);
        return {bank, x0};
    endfunction

    function automatic logic [3:0] lb_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    function automatic logic [31:0] lb_addr_place(input logic [1:0] idx, input logic [7:0] a);
        return {24'h0, a} << {idx, 3'b000};
    endfunction

endpackage

// File: rtl/linebuffer_ctrl_if.sv
// Renderer/timing inputs and line-buffer control outputs of the sequencer.
// master = renderer + video timing side, slave = the sequencer.
interface linebuffer_ctrl_if;

    logic        PIX_EN;
    logic        LINE_START;
    logic        SPR_LOAD;
    logic [8:0]  SPR_X;
    logic        SPR_PIX_VALID;
    logic [3:0]  SPR_COLOR;
    logic        SPR_READY;
    logic [3:0]  LB_CK;
    logic [3:0]  LB_LOAD;
    logic [31:0] LB_ADDR;
    logic [3:0]  LB_WE;
    logic [3:0]  LB_CLEARING;
    logic [3:0]  COLOR_OUT;
    logic        WR_BANK;
    logic [1:0]  RD_SEL;
    logic        RD_ACTIVE;

    modport master (
        output PIX_EN, LINE_START, SPR_LOAD, SPR_X, SPR_PIX_VALID, SPR_COLOR,
        input  SPR_READY, LB_CK, LB_LOAD, LB_ADDR, LB_WE, LB_CLEARING,
        input  COLOR_OUT, WR_BANK, RD_SEL, RD_ACTIVE
    );

    modport slave (
        input  PIX_EN, LINE_START, SPR_LOAD, SPR_X, SPR_PIX_VALID, SPR_COLOR,
        output SPR_READY, LB_CK, LB_LOAD, LB_ADDR, LB_WE, LB_CLEARING,
        output COLOR_OUT, WR_BANK, RD_SEL, RD_ACTIVE
    );

endinterface

// File: rtl/linebuffer_ctrl_rd.sv
// Read-out/clear sequencer: per pixel enable, address-load strobe then write-backdrop strobe on the read bank.
// Latency: strobes 1 and 2 CLK after PIX_EN; no backpressure, PIX_EN outside R_WAIT is ignored.
module linebuffer_ctrl_rd
    import linebuffer_ctrl_pkg::*;
#(
    parameter int ACTIVE_PIX = 320
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       pix_en,
    input  logic       line_start,
    input  logic       wr_bank,
    output lb_ctl_t    rd_ctl,
    output logic [1:0] rd_sel,
    output logic       rd_active
);

    localparam logic [8:0] LAST_X = 9'(ACTIVE_PIX);

    rd_state_t  state;
    logic [8:0] rx;
    logic [8:0] rx_nxt;
    logic [1:0] r_idx;

    assign rx_nxt = rx + 9'd1;
    assign r_idx  = lb_buf_idx(~wr_bank, rx[0]);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state     <= LB_R_IDLE;
            rx        <= '0;
            rd_sel    <= '0;
            rd_active <= 1'b0;
            rd_ctl    <= LB_CTL_IDLE;
        end else begin
            // Strobes are single-cycle: every state that wants one sets it again.
            rd_ctl <= LB_CTL_IDLE;
            if (line_start) begin
                state     <= LB_R_WAIT;
                rx        <= '0;
                rd_active <= 1'b1;
            end else begin
                case (state)
                    LB_R_WAIT: begin
                        if (pix_en) begin
                            state       <= LB_R_ADDR;
                            rd_sel      <= r_idx;
                            rd_ctl.ck   <= lb_onehot(r_idx);
                            rd_ctl.load <= ~lb_onehot(r_idx);
                            rd_ctl.addr <= lb_addr_place(r_idx, rx[8:1]);
                        end
                    end
                    LB_R_ADDR: begin
                        state      <= LB_R_CLR;
                        rd_ctl.we  <= lb_onehot(rd_sel);
                        rd_ctl.clr <= lb_onehot(rd_sel);
                    end
                    LB_R_CLR: begin
                        rx <= rx_nxt;
                        if (rx_nxt == LAST_X) begin
                            state     <= LB_R_DONE;
                            rd_active <= 1'b0;
                        end else begin
                            state <= LB_R_WAIT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/linebuffer_ctrl.sv
// Sprite line-buffer sequencer: renderer writes one bank while the other is read out and cleared; banks swap per line.
// Latency: write strobes in the accepting cycle, read strobes 1-2 CLK after PIX_EN; SPR_READY low outside W_RUN and on LINE_START.
module linebuffer_ctrl
    import linebuffer_ctrl_pkg::*;
#(
    parameter int ACTIVE_PIX = 320,
    parameter bit BANK_RESET = 1'b0
) (
    input  logic             CLK,
    input  logic             nRESET,
    linebuffer_ctrl_if.slave lb
);

    wr_state_t  w_state;
    logic [8:0] wx;
    logic       wr_bank_q;
    logic       ready_q;
    logic       accept;
    logic [1:0] wr_b;
    lb_ctl_t    wr_ctl;
    lb_ctl_t    rd_ctl;
    logic [3:0] color_out;

    // LINE_START wins over a coincident pixel, so it masks READY combinationally.
    assign lb.SPR_READY = ready_q & ~lb.LINE_START;
    assign accept       = lb.SPR_PIX_VALID & lb.SPR_READY;
    assign wr_b         = lb_buf_idx(wr_bank_q, wx[0]);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            w_state   <= LB_W_IDLE;
            wx        <= '0;
            wr_bank_q <= BANK_RESET;
            ready_q   <= 1'b0;
        end else if (lb.LINE_START) begin
            wr_bank_q <= ~wr_bank_q;
            w_state   <= LB_W_IDLE;
            ready_q   <= 1'b0;
        end else if (lb.SPR_LOAD) begin
            wx      <= lb.SPR_X;
            w_state <= LB_W_LOAD;
            ready_q <= 1'b0;
        end else begin
            case (w_state)
                LB_W_LOAD: begin
                    w_state <= LB_W_RUN;
                    ready_q <= 1'b1;
                end
                LB_W_RUN: begin
                    if (accept) wx <= wx + 9'd1;
                end
                default: ;
            endcase
        end
    end

    // Off-line pixels (x >= LB_XMAX) still clock the counter so X keeps advancing.
    always_comb begin
        wr_ctl    = LB_CTL_IDLE;
        color_out = '0;
        if (accept) begin
            wr_ctl.ck   = lb_onehot(wr_b);
            wr_ctl.load = ~lb_onehot(wr_b);
            wr_ctl.addr = lb_addr_place(wr_b, wx[8:1]);
            color_out   = lb.SPR_COLOR;
            if ((lb.SPR_COLOR != 4'h0) && (wx < 9'(LB_XMAX)))
                wr_ctl.we = lb_onehot(wr_b);
        end
    end

    linebuffer_ctrl_rd #(
        .ACTIVE_PIX (ACTIVE_PIX)
    ) u_rd (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .pix_en     (lb.PIX_EN),
        .line_start (lb.LINE_START),
        .wr_bank    (wr_bank_q),
        .rd_ctl     (rd_ctl),
        .rd_sel     (lb.RD_SEL),
        .rd_active  (lb.RD_ACTIVE)
    );

    // Read and write sides always target opposite banks, so per-bit merge is safe.
    assign lb.LB_CK       = wr_ctl.ck   | rd_ctl.ck;
    assign lb.LB_LOAD     = wr_ctl.load & rd_ctl.load;
    assign lb.LB_ADDR     = wr_ctl.addr | rd_ctl.addr;
    assign lb.LB_WE       = wr_ctl.we   | rd_ctl.we;
    assign lb.LB_CLEARING = wr_ctl.clr  | rd_ctl.clr;
    assign lb.COLOR_OUT   = color_out;
    assign lb.WR_BANK     = wr_bank_q;

    bank_no_collide: assert property (@(posedge CLK) disable iff (!nRESET)
        (wr_ctl.ck & rd_ctl.ck) == 4'h0 && (wr_ctl.we & rd_ctl.we) == 4'h0);

endmodule

// File: tb/tb_linebuffer_ctrl.sv
// Randomized bench for linebuffer_ctrl against a per-pixel reference model of bank swap, strip writes and read-out/clear.
module tb_linebuffer_ctrl;

    localparam int ACTIVE_PIX = 320;
    localparam bit BANK_RESET = 1'b0;
    localparam int LINE_LEN   = 2000;

    logic CLK    = 1'b0;
    logic nRESET = 1'b0;
    always #5 CLK = ~CLK;

    linebuffer_ctrl_if lbi();

    linebuffer_ctrl #(
        .ACTIVE_PIX (ACTIVE_PIX),
        .BANK_RESET (BANK_RESET)
    ) dut (
        .CLK    (CLK),
        .nRESET (nRESET),
        .lb     (lbi)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: what the buffers should see, expressed in pixels and cycle numbers.
    bit m_wr_bank;
    bit m_wr_act;
    int m_wr_rdy_cyc;
    int m_wx;
    int m_rd_left;
    int m_rd_issue;
    int m_ck_at, m_clr_at, m_op_buf, m_op_addr;
    int m_rd_sel;

    typedef struct {
        bit ld;
        int x;
        bit v;
        int col;
    } spr_step_t;
    spr_step_t script[$];

    int pe_cnt     = 3;
    bit rst_on_clr = 1'b0;
    bit rst_hit    = 1'b0;

    function automatic spr_step_t mk(input bit ld, input int x, input bit v, input int col);
        spr_step_t s;
        s.ld = ld; s.x = x; s.v = v; s.col = col;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_wr_bank    = BANK_RESET;
        m_wr_act     = 1'b0;
        m_wr_rdy_cyc = 0;
        m_wx         = 0;
        m_rd_left    = 0;
        m_rd_issue   = 0;
        m_ck_at      = -1;
        m_clr_at     = -1;
        m_op_buf     = 0;
        m_op_addr    = 0;
        m_rd_sel     = 0;
    endtask

    // One CLK: drive at posedge+1, check at negedge, advance the model.
    task automatic cycle(input int c);
        bit ls, pe, ld, v, rdy, acc;
        int x, col, b, idx;
        spr_step_t s;
        logic [3:0]  e_ck, e_load, e_we, e_clr;
        logic [31:0] e_addr, a_mask;

        ls = (c == 0);
        pe = 1'b0;
        if (c == 0) pe_cnt = 3;
        else if (pe_cnt == 0) begin pe = 1'b1; pe_cnt = $urandom_range(3, 5); end
        else pe_cnt--;

        if (c >= 1 && script.size() > 0) begin
            s = script.pop_front();
            ld = s.ld; x = s.x; v = s.v; col = s.col;
        end else begin
            ld  = ($urandom_range(0, 49) == 0);
            x   = ($urandom_range(0, 2) == 0) ? $urandom_range(370, 400) : $urandom_range(0, 511);
            v   = ($urandom_range(0, 3) != 0) || ls;
            col = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
        end

        lbi.LINE_START    = ls;
        lbi.PIX_EN        = pe;
        lbi.SPR_LOAD      = ld;
        lbi.SPR_X         = 9'(x);
        lbi.SPR_PIX_VALID = v;
        lbi.SPR_COLOR     = 4'(col);

        @(negedge CLK);
        e_ck = 4'h0; e_load = 4'hF; e_we = 4'h0; e_clr = 4'h0; e_addr = '0; a_mask = '0;
        rdy = nRESET && m_wr_act && (cyc >= m_wr_rdy_cyc) && !ls;
        acc = rdy && v;
        if (acc) begin
            b = (m_wr_bank ? 2 : 0) + (m_wx % 2);
            e_ck[b] = 1'b1;
            e_load[b] = 1'b0;
            e_addr[8*b +: 8] = 8'(m_wx / 2);
            a_mask[8*b +: 8] = 8'hFF;
            if (col != 0 && m_wx < 384) e_we[b] = 1'b1;
        end
        if (cyc == m_ck_at) begin
            e_ck[m_op_buf] = 1'b1;
            e_load[m_op_buf] = 1'b0;
            e_addr[8*m_op_buf +: 8] = 8'(m_op_addr);
            a_mask[8*m_op_buf +: 8] = 8'hFF;
            m_rd_sel = m_op_buf;
        end
        if (cyc == m_clr_at) begin
            e_we[m_op_buf]  = 1'b1;
            e_clr[m_op_buf] = 1'b1;
        end

        chk("lb_ck",     lbi.LB_CK, e_ck);
        chk("lb_load",   lbi.LB_LOAD, e_load);
        chk("lb_we",     lbi.LB_WE, e_we);
        chk("lb_clear",  lbi.LB_CLEARING, e_clr);
        chk("lb_addr",   lbi.LB_ADDR & a_mask, e_addr);
        chk("spr_ready", lbi.SPR_READY, rdy);
        chk("wr_bank",   lbi.WR_BANK, m_wr_bank);
        chk("rd_active", lbi.RD_ACTIVE, (m_rd_left > 0));
        chk("rd_sel",    lbi.RD_SEL, m_rd_sel);
        if (acc) chk("color_out", lbi.COLOR_OUT, col);

        if (rst_on_clr && cyc == m_clr_at) begin
            nRESET = 1'b0;
            #1;
            chk("async_we",    lbi.LB_WE, 0);
            chk("async_clear", lbi.LB_CLEARING, 0);
            chk("async_ck",    lbi.LB_CK, 0);
            chk("async_ready", lbi.SPR_READY, 0);
            rst_hit    = 1'b1;
            rst_on_clr = 1'b0;
        end

        if (!nRESET) begin
            model_reset();
        end else begin
            if (cyc == m_clr_at) m_rd_left--;
            if (acc) m_wx = (m_wx + 1) % 512;
            if (ls) begin
                m_wr_bank  = ~m_wr_bank;
                m_wr_act   = 1'b0;
                m_rd_left  = ACTIVE_PIX;
                m_rd_issue = ACTIVE_PIX;
                m_ck_at    = -1;
                m_clr_at   = -1;
            end else begin
                if (ld) begin
                    m_wr_act     = 1'b1;
                    m_wx         = x;
                    m_wr_rdy_cyc = cyc + 2;
                end
                if (pe && m_rd_issue > 0 && cyc > m_clr_at) begin
                    idx        = ACTIVE_PIX - m_rd_issue;
                    m_op_buf   = (m_wr_bank ? 0 : 2) + (idx % 2);
                    m_op_addr  = idx / 2;
                    m_ck_at    = cyc + 1;
                    m_clr_at   = cyc + 2;
                    m_rd_issue--;
                end
            end
        end
        cyc++;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        lbi.LINE_START = 1'b0; lbi.PIX_EN = 1'b0; lbi.SPR_LOAD = 1'b0;
        lbi.SPR_X = '0; lbi.SPR_PIX_VALID = 1'b0; lbi.SPR_COLOR = '0;
        model_reset();
        @(posedge CLK);
        #1;
        repeat (3) cycle(1);
        nRESET = 1'b1;
        repeat (3) cycle(1);

        // Strip at X=10 (colors 5,0,7,3), then a strip straddling the visible edge at 384.
        script.push_back(mk(1'b1, 10, 1'b0, 0));
        script.push_back(mk(1'b0, 0, 1'b0, 0));
        script.push_back(mk(1'b0, 0, 1'b1, 5));
        script.push_back(mk(1'b0, 0, 1'b1, 0));
        script.push_back(mk(1'b0, 0, 1'b1, 7));
        script.push_back(mk(1'b0, 0, 1'b1, 3));
        script.push_back(mk(1'b1, 382, 1'b0, 0));
        script.push_back(mk(1'b0, 0, 1'b0, 0));
        repeat (4) script.push_back(mk(1'b0, 0, 1'b1, 1));

        for (int line = 0; line < 4; line++)
            for (int c = 0; c < LINE_LEN; c++) cycle(c);

        for (int c = 0; c < LINE_LEN; c++) begin
            if (c == 150) rst_on_clr = 1'b1;
            cycle(c);
            if (rst_hit) break;
        end
        chk("rst_in_clr_hit", rst_hit, 1);
        repeat (3) cycle(1);
        nRESET = 1'b1;
        repeat (2) cycle(1);
        for (int c = 0; c < 400; c++) cycle(c);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
